cache_refill_engine: RTL and testbench



---
 rtl/cache_pkg.sv | 51 +++++
 rtl/cache_refill_word_sel.sv | 12 +
 rtl/cache_refill_engine.sv | 158 +++++++++++++++
 tb/tb_cache_refill_engine.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - shared cache definitions: line geometry, address slices, memory messages, refill states
package cache_pkg;

    localparam int WORDS_PER_LINE   = 16;
    localparam int LINE_OFFSET_BITS = 6;
    localparam int WORD_IDX_BITS    = 4;

    localparam int ADDR_TAG_MSB   = 31;
    localparam int ADDR_TAG_LSB   = 11;
    localparam int ADDR_INDEX_MSB = 10;
    localparam int ADDR_INDEX_LSB = 6;
    localparam int ADDR_WORD_MSB  = 5;
    localparam int ADDR_WORD_LSB  = 2;

    localparam logic [2:0] VC_MEM_REQ_MSG_TYPE_READ   = 3'd0;
    localparam logic [2:0] VC_MEM_REQ_MSG_TYPE_WRITE  = 3'd1;
    localparam logic [2:0] VC_MEM_RESP_MSG_TYPE_READ  = 3'd0;
    localparam logic [2:0] VC_MEM_RESP_MSG_TYPE_WRITE = 3'd1;

    typedef struct packed {
        logic [2:0]  type_;
        logic [7:0]  opaque;
        logic [31:0] addr;
        logic [1:0]  len;
        logic [31:0] data;
    } mem_req_4B_t;

    typedef struct packed {
        logic [2:0]  type_;
        logic [7:0]  opaque;
        logic [1:0]  test;
        logic [1:0]  len;
        logic [31:0] data;
    } mem_resp_4B_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WB,
        ST_FILL,
        ST_DONE
    } refill_state_e;

    // Word-aligned byte address of word idx within a line.
    function automatic logic [31:0] line_word_addr(
        input logic [31-LINE_OFFSET_BITS:0] base,
        input logic [WORD_IDX_BITS-1:0]     idx
    );
        return {base, idx, 2'b00};
    endfunction

endpackage

// File: rtl/cache_refill_word_sel.sv
// rtl/cache_refill_word_sel.sv - selects one 32-bit word out of a 512-bit victim line
module cache_refill_word_sel
    import cache_pkg::*;
(
    input  logic [511:0]              line_i,
    input  logic [WORD_IDX_BITS-1:0]  sel_i,
    output logic [31:0]               word_o
);

    assign word_o = line_i[{sel_i, 5'd0} +: 32];

endmodule

// File: rtl/cache_refill_engine.sv
// rtl/cache_refill_engine.sv - miss refill engine: optional victim writeback then pipelined 16-word line fetch
module cache_refill_engine
    import cache_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic          clk,
    input  logic          reset,

    input  logic          refill_req_val,
    output logic          refill_req_rdy,
    input  logic [31:0]   refill_addr,
    input  logic          refill_wb,
    input  logic [31:0]   wb_addr,
    input  logic [511:0]  wb_line,

    output logic          mem_req_val,
    input  logic          mem_req_rdy,
    output mem_req_4B_t   mem_req_msg,

    input  logic          mem_resp_val,
    output logic          mem_resp_rdy,
    input  mem_resp_4B_t  mem_resp_msg,

    output logic          fill_val,
    output logic [3:0]    fill_word_idx,
    output logic [31:0]   fill_data,
    output logic [4:0]    received_mem_resp_num,
    output logic          refill_done,
    output logic          refill_err
);

    localparam int                 OUT_W      = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [OUT_W-1:0]   OUT_MAX    = OUT_W'(MAX_OUTSTANDING);
    localparam logic [4:0]         LINE_WORDS = 5'(WORDS_PER_LINE);
    localparam logic [4:0]         LAST_WORD  = 5'(WORDS_PER_LINE - 1);
    localparam int                 BASE_W     = 32 - LINE_OFFSET_BITS;

    refill_state_e       state_q;
    logic [4:0]          req_cnt_q;
    logic [4:0]          resp_cnt_q;
    logic [OUT_W-1:0]    outstanding_q;
    logic [4:0]          recv_q;
    logic                err_q;
    logic [BASE_W-1:0]   fill_base_q;
    logic [BASE_W-1:0]   wb_base_q;
    logic [511:0]        wb_line_q;

    logic                active;
    logic                in_wb;
    logic                req_fire;
    logic                resp_fire;
    logic                act_resp;
    logic                last_resp;
    logic [31:0]         wb_word;

    cache_refill_word_sel u_word_sel (
        .line_i (wb_line_q),
        .sel_i  (req_cnt_q[WORD_IDX_BITS-1:0]),
        .word_o (wb_word)
    );

    assign active    = (state_q == ST_WB) || (state_q == ST_FILL);
    assign in_wb     = (state_q == ST_WB);

    // Issue depends only on registered counters so it never loops through mem_req_rdy.
    assign mem_req_val  = active && (req_cnt_q < LINE_WORDS) && (outstanding_q < OUT_MAX);
    assign mem_resp_rdy = (state_q != ST_DONE);

    assign req_fire  = mem_req_val && mem_req_rdy;
    assign resp_fire = mem_resp_val && mem_resp_rdy;
    assign act_resp  = resp_fire && active;
    assign last_resp = act_resp && (resp_cnt_q == LAST_WORD);

    always_comb begin
        mem_req_msg = '0;
        if (active) begin
            mem_req_msg.type_  = in_wb ? VC_MEM_REQ_MSG_TYPE_WRITE : VC_MEM_REQ_MSG_TYPE_READ;
            mem_req_msg.opaque = {4'b0, req_cnt_q[3:0]};
            mem_req_msg.addr   = line_word_addr(in_wb ? wb_base_q : fill_base_q, req_cnt_q[3:0]);
            mem_req_msg.len    = 2'd0;
            mem_req_msg.data   = in_wb ? wb_word : 32'd0;
        end
    end

    assign fill_val              = resp_fire && (state_q == ST_FILL);
    assign fill_word_idx         = mem_resp_msg.opaque[3:0];
    assign fill_data             = mem_resp_msg.data;
    assign refill_req_rdy        = (state_q == ST_IDLE);
    assign refill_done           = (state_q == ST_DONE);
    assign received_mem_resp_num = recv_q;
    assign refill_err            = err_q;

    logic unused_inputs;
    assign unused_inputs = ^{refill_addr[LINE_OFFSET_BITS-1:0], wb_addr[LINE_OFFSET_BITS-1:0],
                             mem_resp_msg.type_, mem_resp_msg.opaque[7:4],
                             mem_resp_msg.test, mem_resp_msg.len};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            req_cnt_q     <= '0;
            resp_cnt_q    <= '0;
            outstanding_q <= '0;
            recv_q        <= '0;
            err_q         <= 1'b0;
            fill_base_q   <= '0;
            wb_base_q     <= '0;
            wb_line_q     <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    // Responses seen here are stale traffic from an aborted refill and are dropped.
                    if (refill_req_val) begin
                        fill_base_q   <= refill_addr[31:LINE_OFFSET_BITS];
                        wb_base_q     <= wb_addr[31:LINE_OFFSET_BITS];
                        wb_line_q     <= wb_line;
                        req_cnt_q     <= '0;
                        resp_cnt_q    <= '0;
                        outstanding_q <= '0;
                        recv_q        <= '0;
                        err_q         <= 1'b0;
                        state_q       <= refill_wb ? ST_WB : ST_FILL;
                    end
                end

                ST_WB, ST_FILL: begin
                    if (req_fire && (req_cnt_q < LINE_WORDS))
                        req_cnt_q <= req_cnt_q + 5'd1;
                    if (act_resp && (resp_cnt_q < LINE_WORDS))
                        resp_cnt_q <= resp_cnt_q + 5'd1;

                    if (req_fire && !act_resp)
                        outstanding_q <= outstanding_q + OUT_W'(1);
                    else if (!req_fire && act_resp && (outstanding_q != '0))
                        outstanding_q <= outstanding_q - OUT_W'(1);

                    if (act_resp && (mem_resp_msg.opaque[3:0] != resp_cnt_q[3:0]))
                        err_q <= 1'b1;
                    if (fill_val && (recv_q < LINE_WORDS))
                        recv_q <= recv_q + 5'd1;

                    if (last_resp) begin
                        req_cnt_q     <= '0;
                        resp_cnt_q    <= '0;
                        outstanding_q <= '0;
                        state_q       <= in_wb ? ST_FILL : ST_DONE;
                    end
                end

                ST_DONE: state_q <= ST_IDLE;

                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cache_refill_engine.sv
// tb/tb_cache_refill_engine.sv - scoreboard bench for cache_refill_engine with a queued memory model
module tb_cache_refill_engine;
    import cache_pkg::*;

    logic         clk = 1'b0;
    logic         reset;
    logic         refill_req_val, refill_req_rdy, refill_wb;
    logic [31:0]  refill_addr, wb_addr;
    logic [511:0] wb_line;
    logic         mem_req_val, mem_req_rdy, mem_resp_val, mem_resp_rdy;
    mem_req_4B_t  mem_req_msg;
    mem_resp_4B_t mem_resp_msg;
    logic         fill_val, refill_done, refill_err;
    logic [3:0]   fill_word_idx;
    logic [31:0]  fill_data;
    logic [4:0]   received_mem_resp_num;

    always #5 clk = ~clk;

    cache_refill_engine #(.MAX_OUTSTANDING(4)) dut (
        .clk(clk), .reset(reset),
        .refill_req_val(refill_req_val), .refill_req_rdy(refill_req_rdy),
        .refill_addr(refill_addr), .refill_wb(refill_wb), .wb_addr(wb_addr), .wb_line(wb_line),
        .mem_req_val(mem_req_val), .mem_req_rdy(mem_req_rdy), .mem_req_msg(mem_req_msg),
        .mem_resp_val(mem_resp_val), .mem_resp_rdy(mem_resp_rdy), .mem_resp_msg(mem_resp_msg),
        .fill_val(fill_val), .fill_word_idx(fill_word_idx), .fill_data(fill_data),
        .received_mem_resp_num(received_mem_resp_num),
        .refill_done(refill_done), .refill_err(refill_err)
    );

    typedef struct { logic [2:0] type_; logic [7:0] opaque; logic [31:0] addr; logic [31:0] data; } exp_req_t;
    typedef struct { logic [3:0] idx; logic [31:0] data; logic [4:0] num; } exp_fill_t;
    typedef struct { logic [2:0] type_; logic [7:0] opaque; logic [31:0] data; int ready; } pend_t;

    exp_req_t  exp_req[$];
    exp_fill_t exp_fill[$];
    pend_t     pend[$];

    int errors = 0, checks = 0, cyc = 0;
    int mem_lat = 1, bp_cnt = 0, resp_sel = 0, max_pend = 0, fill_count = 0;
    bit bp_mode = 0, ooo_mode = 0, ooo_used = 0, held_v = 0;
    mem_req_4B_t held;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Memory responder: presents the oldest due response, optionally swapping words 2 and 3.
    initial begin
        mem_req_rdy = 1'b1; mem_resp_val = 1'b0; mem_resp_msg = '0;
        forever begin
            @(posedge clk); #1;
            mem_req_rdy = bp_mode ? (bp_cnt % 3 == 0) : 1'b1;
            bp_cnt++;
            resp_sel = 0;
            mem_resp_val = 1'b0;
            mem_resp_msg = '0;
            if (pend.size() > 0) begin
                if (ooo_mode && !ooo_used && pend[0].opaque == 8'd2) begin
                    if (pend.size() >= 2 && pend[1].ready <= cyc) begin
                        resp_sel = 1; ooo_used = 1; mem_resp_val = 1'b1;
                    end
                end else if (pend[0].ready <= cyc) begin
                    mem_resp_val = 1'b1;
                end
                if (mem_resp_val) begin
                    mem_resp_msg.type_  = pend[resp_sel].type_;
                    mem_resp_msg.opaque = pend[resp_sel].opaque;
                    mem_resp_msg.data   = pend[resp_sel].data;
                end
            end
        end
    end

    // Monitor: pops expectations whenever the DUT presents a request or a fill word.
    initial begin
        exp_req_t  e;
        exp_fill_t f;
        forever begin
            @(negedge clk);
            if (held_v && mem_req_val) check("req_msg_stable", mem_req_msg, held);
            held_v = mem_req_val && !mem_req_rdy;
            held   = mem_req_msg;

            if (fill_val) begin
                if (exp_fill.size() == 0) check("fill_unexpected", 1, 0);
                else begin
                    f = exp_fill.pop_front();
                    check("fill_idx", fill_word_idx, f.idx);
                    check("fill_data", fill_data, f.data);
                    check("fill_num", received_mem_resp_num, f.num);
                end
                fill_count++;
            end

            if (mem_resp_val && mem_resp_rdy) pend.delete(resp_sel);

            if (mem_req_val && mem_req_rdy) begin
                if (exp_req.size() == 0) check("req_unexpected", 1, 0);
                else begin
                    e = exp_req.pop_front();
                    check("req_type", mem_req_msg.type_, e.type_);
                    check("req_opaque", mem_req_msg.opaque, e.opaque);
                    check("req_addr", mem_req_msg.addr, e.addr);
                    check("req_data", mem_req_msg.data, e.data);
                    check("req_len", mem_req_msg.len, 0);
                end
                pend.push_back('{type_: mem_req_msg.type_, opaque: mem_req_msg.opaque,
                                 data: (mem_req_msg.type_ == VC_MEM_REQ_MSG_TYPE_READ) ?
                                       {16'hBEEF, mem_req_msg.addr[15:0]} : 32'd0,
                                 ready: cyc + mem_lat});
            end
            if (pend.size() > max_pend) max_pend = pend.size();
        end
    end

    task automatic push_reqs(input logic [2:0] t, input logic [31:0] base, input bit wr);
        for (int i = 0; i < 16; i++)
            exp_req.push_back('{type_: t, opaque: 8'(i), addr: base + 32'(4 * i),
                                data: wr ? 32'hA000_0000 + 32'(i) : 32'd0});
    endtask

    task automatic push_fills(input logic [31:0] base, input bit swap);
        int idx;
        for (int k = 0; k < 16; k++) begin
            idx = (swap && k == 2) ? 3 : (swap && k == 3) ? 2 : k;
            exp_fill.push_back('{idx: 4'(idx), data: {16'hBEEF, base[15:0] + 16'(4 * idx)}, num: 5'(k)});
        end
    endtask

    task automatic accept(input logic [31:0] a, input bit wb, input logic [31:0] wa, output int t0);
        check("req_rdy_before_accept", refill_req_rdy, 1);
        refill_req_val = 1'b1; refill_addr = a; refill_wb = wb; wb_addr = wa;
        t0 = cyc;
        @(posedge clk); #1;
        refill_req_val = 1'b0;
    endtask

    task automatic run_refill(input logic [31:0] a, input bit wb, input logic [31:0] wa, output int lat);
        int t0;
        accept(a, wb, wa, t0);
        lat = -1;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (refill_done) begin lat = cyc - t0; break; end
        end
        check("recv_num_in_done", received_mem_resp_num, 16);
        @(negedge clk);
        check("done_one_pulse", refill_done, 0);
        check("rdy_after_done", refill_req_rdy, 1);
        check("recv_num_held", received_mem_resp_num, 16);
        check("exp_req_drained", exp_req.size(), 0);
        check("exp_fill_drained", exp_fill.size(), 0);
        @(posedge clk); #1;
    endtask

    task automatic check_reset_outputs();
        check("rst_req_rdy", refill_req_rdy, 1);
        check("rst_resp_rdy", mem_resp_rdy, 1);
        check("rst_req_val", mem_req_val, 0);
        check("rst_fill_val", fill_val, 0);
        check("rst_done", refill_done, 0);
        check("rst_err", refill_err, 0);
        check("rst_recv_num", received_mem_resp_num, 0);
        check("rst_req_msg", mem_req_msg, 0);
    endtask

    initial begin
        int lat, t0, fc, stale;
        reset = 1'b0; refill_req_val = 1'b0; refill_addr = '0; refill_wb = 1'b0; wb_addr = '0;
        for (int i = 0; i < 16; i++) wb_line[32*i +: 32] = 32'hA000_0000 + 32'(i);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs();
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;

        // Clean fill with 1-cycle memory; low address bits must be ignored.
        push_reqs(VC_MEM_REQ_MSG_TYPE_READ, 32'h0000_1A40, 0);
        push_fills(32'h0000_1A40, 0);
        run_refill(32'h0000_1A47, 0, 32'h0, lat);
        check("fill_latency", lat, 18);
        check("fill_err", refill_err, 0);

        // Writeback then fill.
        push_reqs(VC_MEM_REQ_MSG_TYPE_WRITE, 32'h0000_8040, 1);
        push_reqs(VC_MEM_REQ_MSG_TYPE_READ, 32'h0000_2C80, 0);
        push_fills(32'h0000_2C80, 0);
        run_refill(32'h0000_2C80, 1, 32'h0000_8040, lat);
        check("wb_fill_latency", lat, 35);

        // Request backpressure 1,0,0 and 5-cycle memory.
        bp_mode = 1; mem_lat = 5;
        push_reqs(VC_MEM_REQ_MSG_TYPE_READ, 32'h0000_3000, 0);
        push_fills(32'h0000_3000, 0);
        run_refill(32'h0000_3000, 0, 32'h0, lat);
        check("bp_done_seen", lat > 0, 1);
        check("bp_max_outstanding", max_pend <= 4, 1);
        bp_mode = 0;

        // Word 3 returned where word 2 is expected.
        ooo_mode = 1;
        push_reqs(VC_MEM_REQ_MSG_TYPE_READ, 32'h0000_4100, 0);
        push_fills(32'h0000_4100, 1);
        run_refill(32'h0000_4100, 0, 32'h0, lat);
        check("ooo_done_seen", lat > 0, 1);
        check("ooo_err_sticky", refill_err, 1);
        check("ooo_used", ooo_used, 1);
        ooo_mode = 0;

        // Reset after 7 fills; three requests are still in flight.
        push_reqs(VC_MEM_REQ_MSG_TYPE_READ, 32'h0000_5200, 0);
        push_fills(32'h0000_5200, 0);
        fc = fill_count;
        accept(32'h0000_5200, 0, 32'h0, t0);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk); #2;
            if (fill_count - fc >= 7) break;
        end
        check("fills_before_reset", fill_count - fc, 7);
        @(posedge clk); #1;
        reset = 1'b0;
        stale = pend.size();
        check("stale_in_flight", stale, 3);
        exp_req.delete();
        exp_fill.delete();
        fc = fill_count;
        @(negedge clk);
        check_reset_outputs();
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        for (int i = 0; i < 50 && pend.size() != 0; i++) @(negedge clk);
        check("stale_drained", pend.size(), 0);
        check("stale_no_fill", fill_count - fc, 0);
        check("idle_after_drain", refill_req_rdy, 1);
        check("recv_num_after_reset", received_mem_resp_num, 0);
        @(posedge clk); #1;

        // New request after the abort.
        mem_lat = 1;
        push_reqs(VC_MEM_REQ_MSG_TYPE_READ, 32'h0000_6000, 0);
        push_fills(32'h0000_6000, 0);
        run_refill(32'h0000_6000, 0, 32'h0, lat);
        check("post_reset_latency", lat, 18);
        check("post_reset_err", refill_err, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
